// File: rtl/decoded_frame_unloader_pkg.sv
// Shared definitions for the per-frame decoder flow (loader, iteration counter, unloader).
package decoded_frame_unloader_pkg;

  localparam int unsigned STATE_W = 3;

  // One-hot progress encoding, common to the iteration counter and the unloader.
  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 3'b001,
    ST_SEND = 3'b010,
    ST_DONE = 3'b100
  } state_e;

  // True when a bit index sits on the final frame position.
  function automatic logic is_last_index(input logic [7:0] idx, input logic [7:0] last_idx);
    return idx == last_idx;
  endfunction

endpackage

// File: rtl/decoded_frame_unloader.sv
// Drains a decoded LDPC frame, one hard-decision bit per accepted handshake.
module decoded_frame_unloader
  import decoded_frame_unloader_pkg::*;
#(
  parameter int unsigned log2n       = 4,
  parameter int unsigned n           = 12,
  parameter int unsigned n_minus_one = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [n-1:0]     dec_bits,
  input  logic             abort,
  input  logic             out_ready,
  output logic             out_valid,
  output logic             out_bit,
  output logic [log2n-1:0] out_index,
  output logic             out_last,
  output logic             done,
  output logic             overrun,
  output logic [2:0]       state
);

  localparam logic [log2n-1:0] LAST_IDX = log2n'(n_minus_one);

  state_e           state_q, state_d;
  logic [log2n-1:0] idx_q, idx_d;
  logic [n-1:0]     buf_q, buf_d;
  logic             overrun_d;
  logic             out_valid_d;
  logic             out_bit_d;
  logic [log2n-1:0] out_index_d;
  logic             out_last_d;
  logic             done_d;
  logic             at_last;

  // Exact-equality end-of-frame detect; the index never wraps.
  assign at_last = is_last_index(8'(idx_q), 8'(LAST_IDX));

  // Next-state, buffer/index update and next output values.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    buf_d       = buf_q;
    overrun_d   = overrun;
    out_valid_d = 1'b0;
    out_bit_d   = 1'b0;
    out_index_d = '0;
    out_last_d  = 1'b0;
    done_d      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          buf_d   = dec_bits;
          idx_d   = '0;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (start) overrun_d = 1'b1;
        // Abort wins over a same-cycle handshake: that bit is not transferred.
        if (abort) begin
          idx_d   = '0;
          state_d = ST_IDLE;
        end else if (out_ready) begin
          if (at_last) state_d = ST_DONE;
          else         idx_d   = idx_q + log2n'(1);
        end
      end
      ST_DONE: begin
        if (start) overrun_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        idx_d   = '0;
        state_d = ST_IDLE;
      end
    endcase

    // Outputs reflect the upcoming register state so they leave the flops directly.
    if (state_d == ST_SEND) begin
      out_valid_d = 1'b1;
      out_bit_d   = buf_d[idx_d];
      out_index_d = idx_d;
      out_last_d  = (idx_d == LAST_IDX);
    end
    done_d = (state_d == ST_DONE);
  end

  // State, frame buffer, index and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      buf_q     <= '0;
      overrun   <= 1'b0;
      out_valid <= 1'b0;
      out_bit   <= 1'b0;
      out_index <= '0;
      out_last  <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      buf_q     <= buf_d;
      overrun   <= overrun_d;
      out_valid <= out_valid_d;
      out_bit   <= out_bit_d;
      out_index <= out_index_d;
      out_last  <= out_last_d;
      done      <= done_d;
    end
  end

  assign state = 3'(state_q);

endmodule

// File: tb/tb_decoded_frame_unloader.sv
// Directed bench for decoded_frame_unloader (n=12).
module tb_decoded_frame_unloader;

  localparam int unsigned N     = 12;
  localparam int unsigned LOG2N = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [N-1:0]     dec_bits;
  logic             abort;
  logic             out_ready;
  logic             out_valid;
  logic             out_bit;
  logic [LOG2N-1:0] out_index;
  logic             out_last;
  logic             done;
  logic             overrun;
  logic [2:0]       state;

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  decoded_frame_unloader #(.log2n(LOG2N), .n(N), .n_minus_one(N-1)) dut (
    .clk(clk), .rst(rst), .start(start), .dec_bits(dec_bits), .abort(abort),
    .out_ready(out_ready), .out_valid(out_valid), .out_bit(out_bit),
    .out_index(out_index), .out_last(out_last), .done(done),
    .overrun(overrun), .state(state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Start a frame with out_ready high and check every bit, then DONE and return to IDLE.
  task automatic run_frame(input logic [N-1:0] f);
    dec_bits  = f;
    start     = 1'b1;
    out_ready = 1'b1;
    tick();
    start    = 1'b0;
    dec_bits = '0;
    for (int i = 0; i < 12; i++) begin
      chk("frame_valid", 32'(out_valid), 32'd1);
      chk("frame_index", 32'(out_index), 32'(i));
      chk("frame_bit",   32'(out_bit),   32'(f[i]));
      chk("frame_last",  32'(out_last),  32'(i == 11));
      chk("frame_done0", 32'(done),      32'd0);
      tick();
    end
    chk("frame_done",       32'(done),      32'd1);
    chk("frame_state_done", 32'(state),     32'd4);
    chk("frame_valid_done", 32'(out_valid), 32'd0);
    tick();
    chk("frame_state_idle", 32'(state), 32'd1);
    chk("frame_done_clr",   32'(done),  32'd0);
  endtask

  initial begin
    logic [N-1:0] frame;
    logic [11:0]  hand_bits;

    rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0; dec_bits = '0;
    tick();
    tick();
    chk("rst_state",   32'(state),     32'd1);
    chk("rst_valid",   32'(out_valid), 32'd0);
    chk("rst_done",    32'(done),      32'd0);
    chk("rst_overrun", 32'(overrun),   32'd0);
    chk("rst_index",   32'(out_index), 32'd0);
    chk("rst_bit",     32'(out_bit),   32'd0);
    rst = 1'b0;
    repeat (5) tick();
    chk("idle_state", 32'(state),     32'd1);
    chk("idle_valid", 32'(out_valid), 32'd0);
    chk("idle_done",  32'(done),      32'd0);

    // Full frame 12'hA5C, bit order 0,0,1,1,1,0,1,0,0,1,0,1 (written MSB-first below).
    hand_bits = 12'b1010_0101_1100;
    frame = 12'hA5C;
    chk("hand_pattern", 32'(hand_bits), 32'(frame));
    run_frame(frame);

    // Backpressure: stall three cycles at index 4.
    dec_bits = frame; start = 1'b1; out_ready = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (i == 4) begin
        out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          chk("stall_valid", 32'(out_valid), 32'd1);
          chk("stall_index", 32'(out_index), 32'd4);
          chk("stall_bit",   32'(out_bit),   32'(hand_bits[4]));
          tick();
        end
        out_ready = 1'b1;
      end
      chk("bp_index", 32'(out_index), 32'(i));
      chk("bp_bit",   32'(out_bit),   32'(hand_bits[i]));
      chk("bp_done0", 32'(done),      32'd0);
      tick();
    end
    chk("bp_done", 32'(done), 32'd1);
    tick();
    chk("bp_idle", 32'(state), 32'd1);

    // Abort at index 6 with out_ready high.
    dec_bits = 12'h3C9; start = 1'b1; out_ready = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    chk("abort_at_index", 32'(out_index), 32'd6);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_valid", 32'(out_valid), 32'd0);
    chk("abort_state", 32'(state),     32'd1);
    chk("abort_done",  32'(done),      32'd0);
    tick();
    chk("abort_done_late", 32'(done),  32'd0);
    chk("abort_overrun",   32'(overrun), 32'd0);
    run_frame(12'h5A3);

    // Overrun: extra start at index 3 and on the DONE cycle.
    dec_bits = frame; start = 1'b1; out_ready = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      chk("ovr_index", 32'(out_index), 32'(i));
      chk("ovr_bit",   32'(out_bit),   32'(hand_bits[i]));
      if (i == 3) begin
        start = 1'b1; dec_bits = 12'hFFF;
      end
      tick();
      start = 1'b0; dec_bits = '0;
      if (i == 3) chk("ovr_set", 32'(overrun), 32'd1);
    end
    chk("ovr_done", 32'(done), 32'd1);
    start = 1'b1; dec_bits = 12'h0F0;
    tick();
    start = 1'b0; dec_bits = '0;
    chk("ovr_done_start_state", 32'(state),     32'd1);
    chk("ovr_done_start_valid", 32'(out_valid), 32'd0);
    repeat (3) tick();
    chk("ovr_sticky", 32'(overrun), 32'd1);

    // Reset mid-frame at index 8.
    dec_bits = 12'h777; start = 1'b1; out_ready = 1'b1;
    tick();
    start = 1'b0;
    repeat (8) tick();
    chk("mid_at_index", 32'(out_index), 32'd8);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_state",   32'(state),     32'd1);
    chk("mid_rst_valid",   32'(out_valid), 32'd0);
    chk("mid_rst_index",   32'(out_index), 32'd0);
    chk("mid_rst_bit",     32'(out_bit),   32'd0);
    chk("mid_rst_last",    32'(out_last),  32'd0);
    chk("mid_rst_done",    32'(done),      32'd0);
    chk("mid_rst_overrun", 32'(overrun),   32'd0);

    // abort together with start in IDLE: nothing captured.
    abort = 1'b1; start = 1'b1; dec_bits = 12'hFFF;
    tick();
    abort = 1'b0; start = 1'b0; dec_bits = '0;
    chk("abort_start_state", 32'(state),     32'd1);
    chk("abort_start_valid", 32'(out_valid), 32'd0);
    tick();
    chk("abort_start_state2", 32'(state), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
